// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC and tracks the one outstanding memory read.
// Returned words go into a 2-entry skid buffer that feeds decode through
// a valid/ready handshake. Redirect flushes and restarts fetch; halts at LAST_PC.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 10,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [PC_WIDTH-1:0] LAST_PC     = '1
) (
  input  logic                   CLK_SYS,
  input  logic                   RST_SYS_N,
  input  logic                   run,
  output logic [PC_WIDTH-1:0]    imem_pc,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic                   done
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned USE_W = 3;

  logic [PC_WIDTH-1:0]    r_pc, w_pc_nxt;
  logic                   r_inflight, w_inflight_nxt;
  logic [PC_WIDTH-1:0]    r_infl_pc, w_infl_pc_nxt;
  logic                   r_halted, w_halted_nxt;
  logic [CNT_W-1:0]       r_count, w_count_nxt;
  logic [INSTR_WIDTH-1:0] r_hd_instr, w_hd_instr_nxt;
  logic [PC_WIDTH-1:0]    r_hd_pc, w_hd_pc_nxt;
  logic [INSTR_WIDTH-1:0] r_tl_instr, w_tl_instr_nxt;
  logic [PC_WIDTH-1:0]    r_tl_pc, w_tl_pc_nxt;

  logic                   w_pop;
  logic                   w_push;
  logic                   w_issue;
  logic [USE_W-1:0]       w_used;

  assign imem_pc  = r_pc;
  assign if_valid = (r_count != CNT_W'(0));
  assign if_instr = r_hd_instr;
  assign if_pc    = r_hd_pc;
  assign done     = r_halted & ~r_inflight & (r_count == CNT_W'(0));

  // Credit check: issue only if the buffer can absorb every word already owed plus the new one
  always_comb begin
    w_pop   = if_valid & if_ready;
    w_push  = r_inflight;
    w_used  = USE_W'(r_count) + USE_W'(r_inflight);
    w_issue = run & ~r_halted & ~redirect_valid & (w_used < (USE_W'(2) + USE_W'(w_pop)));
  end

  // Next-state for PC, in-flight tracking and the skid buffer
  always_comb begin
    w_pc_nxt       = r_pc;
    w_inflight_nxt = 1'b0;
    w_infl_pc_nxt  = r_infl_pc;
    w_halted_nxt   = r_halted;
    w_count_nxt    = r_count;
    w_hd_instr_nxt = r_hd_instr;
    w_hd_pc_nxt    = r_hd_pc;
    w_tl_instr_nxt = r_tl_instr;
    w_tl_pc_nxt    = r_tl_pc;

    if (redirect_valid) begin
      // Flush: the word still in flight is dropped along with the buffer contents
      w_pc_nxt     = redirect_pc;
      w_halted_nxt = 1'b0;
      w_count_nxt  = CNT_W'(0);
    end else begin
      if (w_issue) begin
        w_inflight_nxt = 1'b1;
        w_infl_pc_nxt  = r_pc;
        w_pc_nxt       = r_pc + PC_WIDTH'(1);
        if (r_pc == LAST_PC) w_halted_nxt = 1'b1;
      end

      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == CNT_W'(0)) begin
            w_hd_instr_nxt = imem_instr;
            w_hd_pc_nxt    = r_infl_pc;
          end else begin
            w_tl_instr_nxt = imem_instr;
            w_tl_pc_nxt    = r_infl_pc;
          end
          w_count_nxt = r_count + CNT_W'(1);
        end
        2'b01: begin
          w_hd_instr_nxt = r_tl_instr;
          w_hd_pc_nxt    = r_tl_pc;
          w_count_nxt    = r_count - CNT_W'(1);
        end
        2'b11: begin
          if (r_count == CNT_W'(1)) begin
            w_hd_instr_nxt = imem_instr;
            w_hd_pc_nxt    = r_infl_pc;
          end else begin
            w_hd_instr_nxt = r_tl_instr;
            w_hd_pc_nxt    = r_tl_pc;
            w_tl_instr_nxt = imem_instr;
            w_tl_pc_nxt    = r_infl_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge CLK_SYS or negedge RST_SYS_N) begin
    if (!RST_SYS_N) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_infl_pc  <= '0;
      r_halted   <= 1'b0;
      r_count    <= '0;
      r_hd_instr <= '0;
      r_hd_pc    <= '0;
      r_tl_instr <= '0;
      r_tl_pc    <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_inflight <= w_inflight_nxt;
      r_infl_pc  <= w_infl_pc_nxt;
      r_halted   <= w_halted_nxt;
      r_count    <= w_count_nxt;
      r_hd_instr <= w_hd_instr_nxt;
      r_hd_pc    <= w_hd_pc_nxt;
      r_tl_instr <= w_tl_instr_nxt;
      r_tl_pc    <= w_tl_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized backpressure,
// with a scoreboard that expects consecutive PCs from the last (re)start point.
module tb_fetch_unit;

  localparam int unsigned PW = 10;
  localparam int unsigned IW = 32;
  localparam logic [31:0] BASE = 32'hA000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          run, redirect_valid, if_ready, if_valid, done;
  logic [PW-1:0] redirect_pc, imem_pc, if_pc;
  logic [IW-1:0] imem_instr, if_instr;

  logic          h_run, h_redirect_valid, h_ready, h_if_valid, h_done;
  logic [PW-1:0] h_redirect_pc, h_imem_pc, h_if_pc;
  logic [IW-1:0] h_imem_instr, h_if_instr;

  int n_vec = 0;
  int n_err = 0;
  int exp_pc = 0;
  int h_exp_pc = 0;
  int n_words = 0;

  fetch_unit u_dut (
    .CLK_SYS(clk), .RST_SYS_N(rst_n), .run(run), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .done(done)
  );

  fetch_unit #(.LAST_PC(10'd5)) u_dut_h (
    .CLK_SYS(clk), .RST_SYS_N(rst_n), .run(h_run), .imem_pc(h_imem_pc), .imem_instr(h_imem_instr),
    .redirect_valid(h_redirect_valid), .redirect_pc(h_redirect_pc), .if_valid(h_if_valid),
    .if_ready(h_ready), .if_instr(h_if_instr), .if_pc(h_if_pc), .done(h_done)
  );

  // Synchronous instruction memories: mem[i] = BASE + i, one-cycle read
  always @(posedge clk) imem_instr   <= BASE + 32'(imem_pc);
  always @(posedge clk) h_imem_instr <= BASE + 32'(h_imem_pc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Score any handshake about to complete, then advance one clock
  task automatic cycle();
    if (if_valid && if_ready) begin
      chk("sb_pc", 32'(if_pc), 32'(exp_pc));
      chk("sb_instr", if_instr, BASE + 32'(exp_pc));
      exp_pc = (exp_pc + 1) % 1024;
      n_words++;
    end
    if (h_if_valid && h_ready) begin
      chk("h_sb_pc", 32'(h_if_pc), 32'(h_exp_pc));
      chk("h_sb_instr", h_if_instr, BASE + 32'(h_exp_pc));
      h_exp_pc = (h_exp_pc + 1) % 1024;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(if_valid), 32'(0));
    chk({tag, "_instr"}, if_instr, 32'(0));
    chk({tag, "_pc"}, 32'(if_pc), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_imem"}, 32'(imem_pc), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    h_run = 1'b0; h_ready = 1'b0; h_redirect_valid = 1'b0; h_redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    chk("rst_h_done", 32'(h_done), 32'(0));

    // Startup latency and gapless streaming
    rst_n = 1'b1; run = 1'b1; if_ready = 1'b1; exp_pc = 0;
    cycle();
    chk("t1_lat1", 32'(if_valid), 32'(0));
    cycle();
    chk("t1_lat2", 32'(if_valid), 32'(1));
    chk("t1_first_pc", 32'(if_pc), 32'(0));
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t1_nogap", 32'(if_valid), 32'(1));
    end
    chk("t1_head4", 32'(if_pc), 32'(4));

    // Stall with a full buffer
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_hold_pc", 32'(if_pc), 32'(4));
      chk("t2_hold_instr", if_instr, BASE + 32'(4));
      chk("t2_imem_frozen", 32'(imem_pc), 32'(6));
    end
    if_ready = 1'b1;
    repeat (4) cycle();
    chk("t2_resume", 32'(exp_pc), 32'(8));
    chk("t2_head8", 32'(if_pc), 32'(8));

    // Redirect with a full buffer and a same-cycle pop
    if_ready = 1'b0;
    repeat (2) cycle();
    chk("t3_head8", 32'(if_pc), 32'(8));
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h200;
    cycle();
    redirect_valid = 1'b0;
    exp_pc = 'h200;
    chk("t3_flush", 32'(if_valid), 32'(0));
    cycle();
    chk("t3_gap", 32'(if_valid), 32'(0));
    cycle();
    chk("t3_valid", 32'(if_valid), 32'(1));
    chk("t3_pc", 32'(if_pc), 32'h200);
    chk("t3_instr", if_instr, BASE + 32'h200);
    repeat (8) cycle();

    // Asynchronous reset mid-stream with a full buffer
    if_ready = 1'b0;
    repeat (3) cycle();
    chk("t5_full", 32'(if_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t5_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1; if_ready = 1'b1; exp_pc = 0;
    cycle();
    chk("t5_lat1", 32'(if_valid), 32'(0));
    cycle();
    chk("t5_restart_valid", 32'(if_valid), 32'(1));
    chk("t5_restart_pc", 32'(if_pc), 32'(0));

    // Random backpressure and run gaps, 200 words
    n_words = 0;
    for (int i = 0; i < 3000 && n_words < 200; i++) begin
      if_ready = 1'($urandom_range(0, 1));
      run = ($urandom_range(0, 9) != 0);
      cycle();
    end
    chk("t6_words", 32'(n_words), 32'(200));

    // Halt at LAST_PC=5, then redirect back to 0
    run = 1'b0; if_ready = 1'b1;
    h_run = 1'b1; h_ready = 1'b1; h_exp_pc = 0;
    for (int i = 0; i < 40 && h_exp_pc != 6; i++) begin
      chk("t4_done_early", 32'(h_done), 32'(0));
      cycle();
    end
    chk("t4_reach", 32'(h_exp_pc), 32'(6));
    chk("t4_done", 32'(h_done), 32'(1));
    chk("t4_valid0", 32'(h_if_valid), 32'(0));
    chk("t4_imem", 32'(h_imem_pc), 32'(6));
    repeat (3) cycle();
    chk("t4_done_hold", 32'(h_done), 32'(1));
    chk("t4_imem_hold", 32'(h_imem_pc), 32'(6));
    h_redirect_valid = 1'b1; h_redirect_pc = '0;
    cycle();
    h_redirect_valid = 1'b0;
    h_exp_pc = 0;
    chk("t4_done_clr", 32'(h_done), 32'(0));
    repeat (6) cycle();
    chk("t4_restart", 32'(h_exp_pc), 32'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
